// File: rtl/shared_mux_arb_pkg.sv
// Shared types and constants for the two-requester shared-mux arbiter.
package shared_mux_arb_pkg;

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] GNT_IDLE = 2'b00;

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = GNT_IDLE,
    G0   = 2'b01,
    G1   = 2'b10
  } state_e;

endpackage

// File: rtl/arb_hold_counter.sv
// Per-grant transfer counter; flags the transfer that reaches the hold limit.
module arb_hold_counter
  import shared_mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit_c
);

  logic [CNT_W-1:0] xfer_cnt;

  // Current transfer is the MAX_HOLD-th one of this grant.
  assign hit_c = inc && (xfer_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (clr) begin
      xfer_cnt <= '0;
    end else if (inc) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shared_mux_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux onto a valid/ready port.
// Optional preemption after MAX_HOLD transfers: SHARED_MUX_ARB_HOLD_LIMIT_EN.
module shared_mux_arbiter
  import shared_mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   sel_q, sel_d;
  logic   xfer_c;
  logic   hold_hit_c;

  assign gnt       = state_q;
  assign sel       = sel_q;
  assign out_valid = |(gnt & req);
  assign out_data  = out_valid ? (sel_q ? data1 : data0) : '0;
  assign xfer_c    = out_valid && out_ready;

`ifdef SHARED_MUX_ARB_HOLD_LIMIT_EN
  logic cnt_clr_c;

  // Counting restarts on any grant change and at each limit hit.
  assign cnt_clr_c = (state_d != state_q) || hold_hit_c;

  arb_hold_counter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (xfer_c),
    .clr  (cnt_clr_c),
    .hit_c(hold_hit_c)
  );
`else
  logic unused_max_hold;

  assign hold_hit_c      = 1'b0;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE: begin
        if (req == 2'b11)  state_d = last_q ? G0 : G1;
        else if (req[0])   state_d = G0;
        else if (req[1])   state_d = G1;
      end
      G0: begin
        if (!req[0])                      state_d = req[1] ? G1 : IDLE;
        else if (hold_hit_c && req[1])    state_d = G1;
      end
      G1: begin
        if (!req[1])                      state_d = req[0] ? G0 : IDLE;
        else if (hold_hit_c && req[0])    state_d = G0;
      end
      default: state_d = IDLE;
    endcase

    // Select and round-robin pointer follow grant entry only; IDLE keeps them.
    if (state_d == G0 && state_q != G0) begin
      last_d = 1'b0;
      sel_d  = 1'b0;
    end
    if (state_d == G1 && state_q != G1) begin
      last_d = 1'b1;
      sel_d  = 1'b1;
    end
  end

endmodule
